// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl_pkg
//  Purpose  : Shared trap-controller FSM state encoding and mcause constants.
//  Revision : 1.0  initial release
// ============================================================================
package trap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRAP     = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_HANDLER  = 3'd3,
        ST_RETURN   = 3'd4
    } trap_state_t;

    // Machine-mode environment call (synchronous exception)
    localparam logic [31:0] CAUSE_ECALL_M  = 32'h0000_000B;
    // Machine external interrupt (interrupt bit 31 set)
    localparam logic [31:0] CAUSE_MEXT_IRQ = 32'h8000_000B;

endpackage
`default_nettype wire

// File: rtl/trap_vec_calc.sv
`default_nettype none
// ============================================================================
//  Module   : trap_vec_calc
//  Purpose  : Combinational trap handler address from mtvec and mcause.
//             Build macro TRAP_VECTORED_EN enables vectored interrupt mode
//             (mtvec[1:0]==2'b01); otherwise direct mode only.
//  Revision : 1.0  initial release
// ============================================================================
module trap_vec_calc (
    input  logic [31:0] mtvec,
    input  logic [31:0] cause,
    output logic [31:0] target
);

    logic [31:0] w_base;
    assign w_base = {mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // Only interrupts are vectored; exceptions always land on the base.
    logic w_vectored;
    assign w_vectored = (mtvec[1:0] == 2'b01) && cause[31];
    assign target     = w_vectored ? (w_base + {25'd0, cause[4:0], 2'b00}) : w_base;

    logic w_unused;
    assign w_unused = ^cause[30:5];
`else
    // Direct mode: mode bits and cause do not affect the target.
    assign target = w_base;

    logic w_unused;
    assign w_unused = ^{mtvec[1:0], cause};
`endif

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl
//  Purpose  : Machine-mode trap controller: ECALL / UART interrupt entry,
//             pipeline flush/stall/redirect sequencing and MRET return.
//             Optional build macro TRAP_VECTORED_EN (see trap_vec_calc).
//  Revision : 1.0  initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        Rst,
    input  logic        ex_valid,
    input  logic        ecall,
    input  logic        mret,
    input  logic        uart_IRQ,
    input  logic [31:0] ID_EX_pres_addr,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        trigger_trap,
    output logic [31:0] trap_epc,
    output logic [31:0] trap_cause,
    output logic        flush,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        trapping
);

    trap_state_t r_state;
    trap_state_t w_next_state;
    logic        r_uart_pend;
    logic        w_irq_en;
    logic        w_take_ecall;
    logic        w_take_irq;
    logic [31:0] w_vec_target;

    // ECALL is accepted in IDLE and (nested) in HANDLER; interrupts only in
    // IDLE, and ECALL has priority so a coincident interrupt stays pending.
    assign w_irq_en     = mstatus_mie & mie_meie & r_uart_pend;
    assign w_take_ecall = ex_valid & ecall &
                          ((r_state == ST_IDLE) || (r_state == ST_HANDLER));
    assign w_take_irq   = w_irq_en & (r_state == ST_IDLE) & ~w_take_ecall;

    trap_vec_calc u_vec_calc (
        .mtvec  (mtvec),
        .cause  (trap_cause),
        .target (w_vec_target)
    );

    // State register
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take_ecall || w_take_irq) begin
                    w_next_state = ST_TRAP;
                end
            end
            ST_TRAP:     w_next_state = ST_REDIRECT;
            ST_REDIRECT: w_next_state = ST_HANDLER;
            ST_HANDLER: begin
                if (w_take_ecall) begin
                    w_next_state = ST_TRAP;
                end else if (ex_valid && mret) begin
                    w_next_state = ST_RETURN;
                end
            end
            ST_RETURN:   w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        trigger_trap = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = 32'd0;
        trapping     = 1'b0;
        case (r_state)
            ST_TRAP: begin
                trigger_trap = 1'b1;
                stall        = 1'b1;
                flush        = 1'b1;
            end
            ST_REDIRECT: begin
                pc_redirect = 1'b1;
                pc_target   = w_vec_target;
                flush       = 1'b1;
            end
            ST_HANDLER: begin
                trapping = 1'b1;
            end
            ST_RETURN: begin
                pc_redirect = 1'b1;
                pc_target   = {mepc[31:2], 2'b00};
                flush       = 1'b1;
                trapping    = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture epc/cause when a trap is accepted; held until the next one
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            trap_epc   <= 32'd0;
            trap_cause <= 32'd0;
        end else if (w_take_ecall) begin
            trap_epc   <= ID_EX_pres_addr;
            trap_cause <= CAUSE_ECALL_M;
        end else if (w_take_irq) begin
            trap_epc   <= ID_EX_pres_addr;
            trap_cause <= CAUSE_MEXT_IRQ;
        end
    end

    // UART pending flag: follows the level request, cleared when serviced
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_uart_pend <= 1'b0;
        end else if (!uart_IRQ || w_take_irq) begin
            r_uart_pend <= 1'b0;
        end else begin
            r_uart_pend <= 1'b1;
        end
    end

    logic w_unused;
    assign w_unused = ^mepc[1:0];

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_trap_ctrl
//  Purpose  : Directed self-checking bench for trap_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;

    logic        clk;
    logic        Rst;
    logic        ex_valid;
    logic        ecall;
    logic        mret;
    logic        uart_IRQ;
    logic [31:0] ID_EX_pres_addr;
    logic        mstatus_mie;
    logic        mie_meie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        trigger_trap;
    logic [31:0] trap_epc;
    logic [31:0] trap_cause;
    logic        flush;
    logic        stall;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        trapping;

    int total = 0;
    int bad   = 0;

    trap_ctrl dut (
        .clk             (clk),
        .Rst             (Rst),
        .ex_valid        (ex_valid),
        .ecall           (ecall),
        .mret            (mret),
        .uart_IRQ        (uart_IRQ),
        .ID_EX_pres_addr (ID_EX_pres_addr),
        .mstatus_mie     (mstatus_mie),
        .mie_meie        (mie_meie),
        .mtvec           (mtvec),
        .mepc            (mepc),
        .trigger_trap    (trigger_trap),
        .trap_epc        (trap_epc),
        .trap_cause      (trap_cause),
        .flush           (flush),
        .stall           (stall),
        .pc_redirect     (pc_redirect),
        .pc_target       (pc_target),
        .trapping        (trapping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compact check of the control outputs
    task automatic chk_ctl(input string tag, input logic tt, input logic st,
                           input logic fl, input logic rd, input logic tr);
        chk({tag, ".trigger"}, {31'd0, trigger_trap}, {31'd0, tt});
        chk({tag, ".stall"},   {31'd0, stall},        {31'd0, st});
        chk({tag, ".flush"},   {31'd0, flush},        {31'd0, fl});
        chk({tag, ".redir"},   {31'd0, pc_redirect},  {31'd0, rd});
        chk({tag, ".trapping"},{31'd0, trapping},     {31'd0, tr});
    endtask

    logic [31:0] exp_vec;

    initial begin
        Rst = 1'b1; ex_valid = 1'b0; ecall = 1'b0; mret = 1'b0; uart_IRQ = 1'b0;
        ID_EX_pres_addr = 32'd0; mstatus_mie = 1'b0; mie_meie = 1'b0;
        mtvec = 32'd0; mepc = 32'd0;

        // Reset state
        #3;
        chk_ctl("rst", 0, 0, 0, 0, 0);
        chk("rst.epc", trap_epc, 32'd0);
        chk("rst.cause", trap_cause, 32'd0);
        chk("rst.target", pc_target, 32'd0);
        tick(); tick();
        Rst = 1'b0;

        // ECALL from IDLE
        mtvec = 32'h0000_0400; ID_EX_pres_addr = 32'h0000_0100;
        ex_valid = 1'b1; ecall = 1'b1;
        tick();
        ex_valid = 1'b0; ecall = 1'b0;
        chk_ctl("ec.trap", 1, 1, 1, 0, 0);
        chk("ec.epc", trap_epc, 32'h0000_0100);
        chk("ec.cause", trap_cause, 32'h0000_000B);
        tick();
        chk_ctl("ec.redir", 0, 0, 1, 1, 0);
        chk("ec.target", pc_target, 32'h0000_0400);
        tick();
        chk_ctl("ec.handler", 0, 0, 0, 0, 1);
        chk("ec.epc_hold", trap_epc, 32'h0000_0100);

        // Interrupt during HANDLER must wait
        uart_IRQ = 1'b1; mstatus_mie = 1'b1; mie_meie = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hdl.no_irq", {31'd0, trigger_trap}, 32'd0);
        end

        // MRET from HANDLER
        mepc = 32'h0000_0104; ID_EX_pres_addr = 32'h0000_0200;
        ex_valid = 1'b1; mret = 1'b1;
        tick();
        ex_valid = 1'b0; mret = 1'b0;
        chk_ctl("ret", 0, 0, 1, 1, 1);
        chk("ret.target", pc_target, 32'h0000_0104);
        tick();
        chk_ctl("ret.idle", 0, 0, 0, 0, 0);

        // Pending interrupt taken once back in IDLE
        mtvec = 32'h0000_0401;
        tick();
        uart_IRQ = 1'b0;
        chk_ctl("irq.trap", 1, 1, 1, 0, 0);
        chk("irq.cause", trap_cause, 32'h8000_000B);
        chk("irq.epc", trap_epc, 32'h0000_0200);
        tick();
`ifdef TRAP_VECTORED_EN
        exp_vec = 32'h0000_042C;
`else
        exp_vec = 32'h0000_0400;
`endif
        chk("irq.target", pc_target, exp_vec);
        tick();
        mepc = 32'h0000_020E; ex_valid = 1'b1; mret = 1'b1;
        tick();
        ex_valid = 1'b0; mret = 1'b0;
        chk("irq.ret_align", pc_target, 32'h0000_020C);
        tick(); tick();
        chk_ctl("irq.cleared", 0, 0, 0, 0, 0);

        // ECALL and interrupt in the same cycle: ECALL wins, interrupt held
        uart_IRQ = 1'b1;
        tick();
        ID_EX_pres_addr = 32'h0000_0300; ex_valid = 1'b1; ecall = 1'b1;
        tick();
        ex_valid = 1'b0; ecall = 1'b0;
        chk("both.cause", trap_cause, 32'h0000_000B);
        chk("both.epc", trap_epc, 32'h0000_0300);
        tick();
        chk("both.exc_base", pc_target, 32'h0000_0400);
        tick();
        mepc = 32'h0000_0304; ex_valid = 1'b1; mret = 1'b1;
        tick();
        ex_valid = 1'b0; mret = 1'b0;
        chk("both.ret", pc_target, 32'h0000_0304);
        ID_EX_pres_addr = 32'h0000_0308;
        tick();
        tick();
        uart_IRQ = 1'b0;
        chk("both.irq_trig", {31'd0, trigger_trap}, 32'd1);
        chk("both.irq_cause", trap_cause, 32'h8000_000B);
        chk("both.irq_epc", trap_epc, 32'h0000_0308);
        tick(); tick();
        ex_valid = 1'b1; mret = 1'b1;
        tick();
        ex_valid = 1'b0; mret = 1'b0;
        tick(); tick();

        // MRET in IDLE is ignored
        ex_valid = 1'b1; mret = 1'b1;
        tick();
        ex_valid = 1'b0; mret = 1'b0;
        chk_ctl("idle_mret", 0, 0, 0, 0, 0);

        // ECALL without ex_valid is ignored
        ecall = 1'b1;
        tick();
        ecall = 1'b0;
        chk("bubble.ecall", {31'd0, trigger_trap}, 32'd0);

        // ECALL and MRET together in IDLE: ECALL taken
        ID_EX_pres_addr = 32'h0000_0500;
        ex_valid = 1'b1; ecall = 1'b1; mret = 1'b1;
        tick();
        ex_valid = 1'b0; ecall = 1'b0; mret = 1'b0;
        chk("ecmret.trig", {31'd0, trigger_trap}, 32'd1);
        chk("ecmret.epc", trap_epc, 32'h0000_0500);

        // Reset in REDIRECT aborts the trap immediately
        tick();
        chk("abort.pre", {31'd0, pc_redirect}, 32'd1);
        #2 Rst = 1'b1;
        #1;
        chk_ctl("abort", 0, 0, 0, 0, 0);
        chk("abort.epc", trap_epc, 32'd0);
        chk("abort.target", pc_target, 32'd0);
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort.quiet", {30'd0, trigger_trap, pc_redirect}, 32'd0);
        end

        // Interrupts disabled globally are never taken
        mstatus_mie = 1'b0; uart_IRQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mie_off", {31'd0, trigger_trap}, 32'd0);
        end
        uart_IRQ = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port Rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port ex_valid, input, 1, EX-stage instruction valid (not bubble); qualifies ecall, mret.
REQ-004 SHALL have port ecall, input, 1, EX-stage instruction is ECALL.
REQ-005 SHALL have port mret, input, 1, EX-stage instruction is MRET.
REQ-006 SHALL have port uart_IRQ, input, 1, UART interrupt request, level, clk domain.
REQ-007 SHALL have port ID_EX_pres_addr, input, 32, PC of EX-stage instruction.
REQ-008 SHALL have ports mstatus_mie (1), mie_meie (1), mtvec (32), mepc (32), inputs, current CSR values.
REQ-009 SHALL have ports trigger_trap (1), trap_epc (32), trap_cause (32), outputs, one-cycle CSR update request.
REQ-010 SHALL have ports flush (1), stall (1), pc_redirect (1), pc_target (32), outputs, pipeline control.
REQ-011 SHALL have port trapping, output, 1, high while handler executes.

Function
REQ-012 SHALL implement FSM states IDLE, TRAP, REDIRECT, HANDLER, RETURN.
REQ-013 Interrupt enable: irq_en = mstatus_mie & mie_meie & uart_pend; uart_pend set on uart_IRQ high, cleared when trap taken for it or uart_IRQ low.
REQ-014 IDLE/HANDLER: ex_valid&ecall -> TRAP, cause 32'h0000_000B, epc = ID_EX_pres_addr.
REQ-015 IDLE only: irq_en (no ecall) -> TRAP, cause 32'h8000_000B, epc = ID_EX_pres_addr; irq never taken in HANDLER/TRAP/REDIRECT/RETURN, stays pending.
REQ-016 Simultaneous ecall and irq_en: ecall wins; irq remains pending.
REQ-017 TRAP (1 cycle): trigger_trap=1, trap_epc/trap_cause held valid, stall=1, flush=1; next REDIRECT.
REQ-018 REDIRECT (1 cycle): pc_redirect=1, pc_target=trap target, flush=1; next HANDLER.
REQ-019 Trap target: {mtvec[31:2],2'b00} (direct mode).
REQ-020 HANDLER: trapping=1; ex_valid&mret -> RETURN.
REQ-021 RETURN (1 cycle): pc_redirect=1, pc_target={mepc[31:2],2'b00}, flush=1; next IDLE; trapping=0 from next cycle.
REQ-022 mret in IDLE SHALL be ignored (no redirect, no state change).
REQ-023 Latency: event sampled cycle N -> trigger_trap N+1, pc_redirect N+2.
REQ-024 All outputs not asserted by current state SHALL be 0; trap_epc/trap_cause hold last captured value.
REQ-025 ecall and mret both asserted: ecall wins.

Reset
REQ-026 Rst high SHALL immediately force state IDLE, uart_pend=0, trap_epc=0, trap_cause=0, all control outputs 0, regardless of clock.
REQ-027 Rst mid-trap (any non-IDLE state) SHALL abort; no trigger_trap or pc_redirect after release until new event.
REQ-028 First event sampled on first rising edge after Rst deasserts.

Configuration
REQ-029 Macro TRAP_VECTORED_EN: defined -> when mtvec[1:0]==2'b01 and cause bit 31 set, target = {mtvec[31:2],2'b00} + 4*cause[4:0]; exceptions always to base.
REQ-030 Undefined: mtvec[1:0] ignored, direct mode only (REQ-019).

Structure
REQ-031 Shared package SHALL hold FSM state enum, cause constants CAUSE_ECALL_M (32'h0000_000B), CAUSE_MEXT_IRQ (32'h8000_000B).
REQ-032 Target-address computation SHALL be sub-module trap_vec_calc (combinational, mtvec+cause -> target); FSM stays in trap_ctrl.

Verification
REQ-033 IDLE, ecall+ex_valid, PC 0x0000_0100, mtvec 0x0000_0400 -> trigger_trap next cycle, epc 0x100, cause 0x0000_000B; redirect to 0x400 following cycle.
REQ-034 HANDLER, mret+ex_valid, mepc 0x0000_0104 -> RETURN, pc_target 0x104, trapping low after.
REQ-035 uart_IRQ=1, mstatus_mie=1, mie_meie=1, PC 0x200 -> cause 0x8000_000B, epc 0x200; with TRAP_VECTORED_EN and mtvec 0x0000_0401 -> target 0x42C.
REQ-036 ecall and irq same cycle -> cause 0x0000_000B; irq held; after mret, irq trap taken in IDLE.
REQ-037 uart_IRQ during HANDLER -> no trap until RETURN completes; mstatus_mie=0 -> never taken.
REQ-038 Rst asserted in REDIRECT -> all outputs 0 same cycle, state IDLE, no redirect after release.
